// File: rtl/ethernet_rx_pkg.sv
// Shared constants and types for the GMII receive framer and its CRC helper.
package ethernet_rx_pkg;

    localparam logic [1:0] ST_DROP     = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_PREAMBLE = 2'd2;
    localparam logic [1:0] ST_DATA     = 2'd3;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    // Four FCS bytes plus the one being forwarded.
    localparam int HOLD_DEPTH = 5;

    typedef struct packed {
        logic good;
        logic crc_err;
        logic len_err;
        logic phy_err;
    } rx_status_t;

endpackage

// File: rtl/ethernet_crc32_byte.sv
// One byte step of the reflected Ethernet CRC-32; also used by the TX FCS generator.
module ethernet_crc32_byte
    import ethernet_rx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c_w;

    always_comb begin
        c_w = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c_w = c_w[0] ? ((c_w >> 1) ^ CRC_POLY) : (c_w >> 1);
        end
        crc_o = c_w;
    end

endmodule

// File: rtl/ethernet_rx_frame_checker.sv
// GMII receive framer: strips preamble/SFD, forwards frame bytes minus FCS,
// and reports CRC/length/PHY status on the final beat. Output never stalls.
module ethernet_rx_frame_checker
    import ethernet_rx_pkg::*;
#(
    parameter  int max_frame_bytes_p = 1518,
    parameter  int min_frame_bytes_p = 64,
    localparam int len_width_lp      = $clog2(max_frame_bytes_p + 2)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    gmii_rx_v_i,
    input  logic                    gmii_rx_dv_i,
    input  logic                    gmii_rx_er_i,
    input  logic [7:0]              gmii_rxd_i,
    output logic [7:0]              data_o,
    output logic                    v_o,
    output logic                    last_o,
    output logic                    status_v_o,
    output logic                    status_good_o,
    output logic                    status_crc_err_o,
    output logic                    status_len_err_o,
    output logic                    status_phy_err_o,
    output logic [len_width_lp-1:0] status_len_o,
    output logic [15:0]             good_cnt_o,
    output logic [15:0]             bad_cnt_o
);

    logic [1:0]                       state_q, state_d;
    logic [len_width_lp-1:0]          len_q, len_d;
    logic [31:0]                      crc_q, crc_d, crc_next;
    logic                             phy_err_q, phy_err_d;
    logic [HOLD_DEPTH-1:0][7:0]       hold_q, hold_d;
    logic [2:0]                       cnt_q, cnt_d;
    logic [7:0]                       data_q, data_d;
    logic                             v_q, v_d, last_q, last_d;
    logic                             status_v_q, status_v_d;
    rx_status_t                       status_q, status_d;
    logic [len_width_lp-1:0]          status_len_q, status_len_d;
    logic [15:0]                      good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;

    logic                             accept;
    logic                             fin, fin_ovf, fin_crc_ok, fin_phy;
    logic [len_width_lp-1:0]          fin_len;

    assign accept = gmii_rx_v_i & gmii_rx_dv_i;

    ethernet_crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (gmii_rxd_i),
        .crc_o  (crc_next)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        crc_d        = crc_q;
        phy_err_d    = phy_err_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        v_d          = 1'b0;
        last_d       = 1'b0;
        status_v_d   = 1'b0;
        status_d     = status_q;
        status_len_d = status_len_q;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        fin          = 1'b0;
        fin_ovf      = 1'b0;
        fin_crc_ok   = 1'b0;
        fin_phy      = 1'b0;
        fin_len      = len_q;

        case (state_q)
            ST_DROP: begin
                if (!gmii_rx_dv_i) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) state_d = (gmii_rxd_i == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
            end
            ST_PREAMBLE: begin
                if (!gmii_rx_dv_i) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    if (gmii_rxd_i == SFD_BYTE) begin
                        state_d   = ST_DATA;
                        len_d     = '0;
                        crc_d     = CRC_INIT;
                        phy_err_d = 1'b0;
                        cnt_d     = '0;
                    end else if (gmii_rxd_i != PREAMBLE_BYTE) begin
                        state_d = ST_DROP;
                    end
                end
            end
            default: begin
                if (!gmii_rx_dv_i) begin
                    // Normal end: the 4 youngest held bytes are the FCS and are discarded.
                    fin        = 1'b1;
                    fin_crc_ok = (crc_q == CRC_RESIDUE);
                    fin_phy    = phy_err_q;
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    if (cnt_q == 3'(HOLD_DEPTH)) begin
                        data_d = hold_q[0];
                        v_d    = 1'b1;
                        last_d = 1'b1;
                    end
                end else begin
                    if (gmii_rx_er_i) phy_err_d = 1'b1;
                    if (accept) begin
                        if (len_q == len_width_lp'(max_frame_bytes_p)) begin
                            fin        = 1'b1;
                            fin_ovf    = 1'b1;
                            fin_len    = len_width_lp'(max_frame_bytes_p + 1);
                            fin_crc_ok = (crc_next == CRC_RESIDUE);
                            fin_phy    = phy_err_q | gmii_rx_er_i;
                            data_d     = hold_q[0];
                            v_d        = 1'b1;
                            last_d     = 1'b1;
                            cnt_d      = '0;
                            state_d    = ST_DROP;
                        end else begin
                            len_d = len_q + 1'b1;
                            crc_d = crc_next;
                            if (cnt_q == 3'(HOLD_DEPTH)) begin
                                data_d = hold_q[0];
                                v_d    = 1'b1;
                                for (int i = 0; i < HOLD_DEPTH - 1; i++) hold_d[i] = hold_q[i+1];
                                hold_d[HOLD_DEPTH-1] = gmii_rxd_i;
                            end else begin
                                hold_d[cnt_q] = gmii_rxd_i;
                                cnt_d         = cnt_q + 1'b1;
                            end
                        end
                    end
                end
            end
        endcase

        if (fin) begin
            status_v_d       = 1'b1;
            status_len_d     = fin_len;
            status_d.crc_err = ~fin_crc_ok;
            status_d.len_err = fin_ovf | (fin_len < len_width_lp'(min_frame_bytes_p));
            status_d.phy_err = fin_phy;
            status_d.good    = fin_crc_ok & ~status_d.len_err & ~fin_phy;
            if (status_d.good) good_cnt_d = good_cnt_q + 16'd1;
            else               bad_cnt_d  = bad_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_DROP;
            len_q        <= '0;
            crc_q        <= '0;
            phy_err_q    <= 1'b0;
            hold_q       <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            v_q          <= 1'b0;
            last_q       <= 1'b0;
            status_v_q   <= 1'b0;
            status_q     <= '0;
            status_len_q <= '0;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            crc_q        <= crc_d;
            phy_err_q    <= phy_err_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            v_q          <= v_d;
            last_q       <= last_d;
            status_v_q   <= status_v_d;
            status_q     <= status_d;
            status_len_q <= status_len_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
        end
    end

    assign data_o           = data_q;
    assign v_o              = v_q;
    assign last_o           = last_q;
    assign status_v_o       = status_v_q;
    assign status_good_o    = status_q.good;
    assign status_crc_err_o = status_q.crc_err;
    assign status_len_err_o = status_q.len_err;
    assign status_phy_err_o = status_q.phy_err;
    assign status_len_o     = status_len_q;
    assign good_cnt_o       = good_cnt_q;
    assign bad_cnt_o        = bad_cnt_q;

endmodule

// File: tb/tb_ethernet_rx_frame_checker.sv
// Randomized and directed frames checked against a byte-queue model of the framer.
module tb_ethernet_rx_frame_checker;

    localparam int MAXB = 1518;
    localparam int MINB = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_v = 1'b0, rx_dv = 1'b0, rx_er = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [7:0]  data_o;
    logic        v_o, last_o, status_v_o, st_good, st_crc, st_len_err, st_phy;
    logic [10:0] st_len;
    logic [15:0] good_cnt, bad_cnt;

    ethernet_rx_frame_checker dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .gmii_rx_v_i      (rx_v),
        .gmii_rx_dv_i     (rx_dv),
        .gmii_rx_er_i     (rx_er),
        .gmii_rxd_i       (rxd),
        .data_o           (data_o),
        .v_o              (v_o),
        .last_o           (last_o),
        .status_v_o       (status_v_o),
        .status_good_o    (st_good),
        .status_crc_err_o (st_crc),
        .status_len_err_o (st_len_err),
        .status_phy_err_o (st_phy),
        .status_len_o     (st_len),
        .good_cnt_o       (good_cnt),
        .bad_cnt_o        (bad_cnt)
    );

    always #4 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [7:0]  body[$];
    logic [7:0]  txq[$];
    logic [7:0]  beat_q[$];
    int          last_idx[$];
    logic [14:0] st_q[$];
    logic        st_last[$];
    logic [15:0] exp_good = 0, exp_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (v_o) begin
            beat_q.push_back(data_o);
            if (last_o) last_idx.push_back(beat_q.size() - 1);
        end
        if (status_v_o) begin
            st_q.push_back({st_good, st_crc, st_len_err, st_phy, st_len});
            st_last.push_back(v_o && last_o);
        end
    end

    function automatic logic [31:0] fcs_of(input int k);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < k; i++) begin
            c ^= {24'h0, body[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Payload (sequential or random) followed by its FCS, LSB byte first.
    task automatic mk_frame(input int n_pay, input bit seq, input int cbyte, input logic [7:0] cmask);
        logic [31:0] f;
        body.delete();
        for (int i = 0; i < n_pay; i++) body.push_back(seq ? 8'(i) : 8'($urandom));
        f = fcs_of(n_pay);
        for (int k = 0; k < 4; k++) body.push_back(f[8*k +: 8]);
        if (cbyte >= 0) body[n_pay + cbyte] ^= cmask;
    endtask

    task automatic clr_mon();
        beat_q.delete(); last_idx.delete(); st_q.delete(); st_last.delete();
    endtask

    task automatic tx(input int rate, input int er_idx);
        for (int i = 0; i < txq.size(); i++) begin
            for (int k = 0; k < rate; k++) begin
                @(posedge clk); #1;
                rx_dv = 1'b1; rx_v = (k == rate - 1); rxd = txq[i]; rx_er = (i == er_idx);
            end
        end
        @(posedge clk); #1;
        rx_dv = 1'b0; rx_v = 1'b0; rx_er = 1'b0; rxd = 8'h00;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic load_preamble_body();
        txq.delete();
        repeat (7) txq.push_back(8'h55);
        txq.push_back(8'hD5);
        foreach (body[i]) txq.push_back(body[i]);
    endtask

    task automatic run(input string tag, input int rate, input int er_body, input bit chk_crc, input bit crc_bad);
        int n, nb, mism;
        bit ovf, phy, lerr, good;
        logic [10:0] elen;
        load_preamble_body();
        clr_mon();
        tx(rate, (er_body < 0) ? -1 : er_body + 8);
        n    = body.size();
        ovf  = (n > MAXB);
        nb   = ovf ? MAXB - 4 : ((n > 4) ? n - 4 : 0);
        phy  = (er_body >= 0) && (er_body <= MAXB);
        elen = ovf ? 11'(MAXB + 1) : 11'(n);
        lerr = (n < MINB) || ovf;
        good = !lerr && !phy && !crc_bad;
        mism = 0;
        for (int i = 0; i < nb && i < beat_q.size(); i++) if (beat_q[i] !== body[i]) mism++;
        chk({tag, "_nbeats"}, beat_q.size(), nb);
        chk({tag, "_data"}, mism, 0);
        chk({tag, "_nlast"}, last_idx.size(), (nb > 0) ? 1 : 0);
        if (nb > 0 && last_idx.size() > 0) chk({tag, "_lastpos"}, last_idx[0], nb - 1);
        chk({tag, "_nstat"}, st_q.size(), 1);
        if (st_q.size() > 0) begin
            chk({tag, "_good"}, st_q[0][14], good);
            if (chk_crc) chk({tag, "_crc_err"}, st_q[0][13], crc_bad);
            chk({tag, "_len_err"}, st_q[0][12], lerr);
            chk({tag, "_phy_err"}, st_q[0][11], phy);
            chk({tag, "_len"}, st_q[0][10:0], elen);
            if (nb > 0) chk({tag, "_st_with_last"}, st_last[0], 1);
        end
        if (good) exp_good++; else exp_bad++;
        chk({tag, "_good_cnt"}, good_cnt, exp_good);
        chk({tag, "_bad_cnt"}, bad_cnt, exp_bad);
    endtask

    task automatic run_silent(input string tag);
        clr_mon();
        tx(1, -1);
        chk({tag, "_nbeats"}, beat_q.size(), 0);
        chk({tag, "_nstat"}, st_q.size(), 0);
        chk({tag, "_good_cnt"}, good_cnt, exp_good);
        chk({tag, "_bad_cnt"}, bad_cnt, exp_bad);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        chk("rst_v", v_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_status_v", status_v_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_len", st_len, 0);
        chk("rst_good_cnt", good_cnt, 0);
        chk("rst_bad_cnt", bad_cnt, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        mk_frame(60, 1'b1, -1, 8'h00);   run("t1_good", 1, -1, 1'b1, 1'b0);
        mk_frame(60, 1'b1, 0, 8'h01);    run("t2_crc", 1, -1, 1'b1, 1'b1);
        mk_frame(60, 1'b1, -1, 8'h00);   run("t3_phy", 1, 20, 1'b1, 1'b0);
        mk_frame(36, 1'b0, -1, 8'h00);   run("t4_runt40", 1, -1, 1'b1, 1'b0);
        body.delete(); body.push_back(8'($urandom)); body.push_back(8'($urandom));
        run("t4_runt2", 1, -1, 1'b0, 1'b1);

        body.delete();
        for (int i = 0; i < 1600; i++) body.push_back(8'($urandom));
        run("t5_ovf", 1, -1, 1'b0, 1'b1);
        mk_frame(60, 1'b0, -1, 8'h00);   run("t5_after", 1, -1, 1'b1, 1'b0);

        mk_frame(60, 1'b1, -1, 8'h00);   run("t6_100m", 10, -1, 1'b1, 1'b0);

        for (int f = 0; f < 8; f++) begin
            int  np, rate, er, cb;
            np   = $urandom_range(20, 150);
            rate = ($urandom_range(0, 2) == 0) ? 10 : 1;
            er   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, np - 1) : -1;
            cb   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            mk_frame(np, 1'b0, cb, 8'h01 << $urandom_range(0, 7));
            run($sformatf("rnd%0d", f), rate, er, 1'b1, cb >= 0);
        end

        txq.delete();
        txq.push_back(8'h55); txq.push_back(8'h55); txq.push_back(8'h55); txq.push_back(8'h12);
        for (int i = 0; i < 70; i++) txq.push_back(8'($urandom));
        run_silent("bad_preamble");

        txq.delete();
        txq.push_back(8'hD5);
        for (int i = 0; i < 70; i++) txq.push_back(8'($urandom));
        run_silent("sfd_no_preamble");

        // Reset pulsed mid-frame: outputs and counters clear, remainder of frame ignored.
        mk_frame(80, 1'b0, -1, 8'h00);
        load_preamble_body();
        clr_mon();
        for (int i = 0; i < txq.size(); i++) begin
            @(posedge clk); #1;
            if (i == 40) rst_n = 1'b0;
            if (i == 50) begin rst_n = 1'b1; clr_mon(); end
            rx_dv = 1'b1; rx_v = 1'b1; rxd = txq[i];
            if (i == 42) begin
                @(negedge clk);
                chk("midrst_v", v_o, 0);
                chk("midrst_good_cnt", good_cnt, 0);
                chk("midrst_bad_cnt", bad_cnt, 0);
            end
        end
        @(posedge clk); #1;
        rx_dv = 1'b0; rx_v = 1'b0; rxd = 8'h00;
        repeat (12) @(posedge clk);
        #1;
        exp_good = 0; exp_bad = 0;
        chk("midrst_nbeats", beat_q.size(), 0);
        chk("midrst_nstat", st_q.size(), 0);
        mk_frame(60, 1'b1, -1, 8'h00);   run("midrst_next", 1, -1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
